// File: rtl/button_input_pio.sv
// Avalon-MM input PIO: synchronizes WIDTH external inputs and latches their edges into a
// write-1-to-clear capture register with a masked level IRQ. Define BUTTON_INPUT_PIO_DEBOUNCE_EN to add per-bit debouncing.
module button_input_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic             bus_write;
  logic             unused_writedata;

  // Upper writedata bits beyond WIDTH have no storage behind them.
  assign unused_writedata = ^writedata;

  assign bus_write = chipselect && !write_n;

  // Two-flop synchronizer for the asynchronous inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef BUTTON_INPUT_PIO_DEBOUNCE_EN
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] deb_cnt [WIDTH];

  // A bit must disagree with stable for DEBOUNCE_CYCLES consecutive clocks to be accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  localparam int unsigned deb_cycles_unused = DEBOUNCE_CYCLES;

  assign stable = sync2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= stable;
    end
  end

  // Edge detection on the stable value, selected at elaboration time.
  always_comb begin
    rise     = stable & ~prev;
    fall     = ~stable & prev;
    edge_set = rise | fall;
    case (EDGE_TYPE)
      0:       edge_set = rise;
      1:       edge_set = fall;
      default: edge_set = rise | fall;
    endcase
  end

  always_comb begin
    edge_clr = '0;
    if (bus_write && (address == ADDR_EDGE)) begin
      edge_clr = writedata[WIDTH-1:0];
    end
  end

  // Sticky capture: a new edge wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (bus_write && (address == ADDR_MASK)) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_capture & irq_mask);
    end
  end

  // Zero-wait-state read mux, independent of chipselect.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(stable);
      ADDR_MASK: readdata = 32'(irq_mask);
      ADDR_EDGE: readdata = 32'(edge_capture);
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_button_input_pio.sv
// Scoreboard bench for button_input_pio: rising, falling and any-edge instances share one
// stimulus stream and are checked against a delay-line reference model.
`timescale 1ns/1ps
module tb_button_input_pio;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEB   = 4;
`ifdef BUTTON_INPUT_PIO_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0][31:0] rd;
    logic [2:0]       irq;
    logic [1:0]       addr;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [WIDTH-1:0] in_port = '0;
  logic [31:0]      rd_out  [3];
  logic             irq_out [3];

  always #5 clk = ~clk;

  for (genvar e = 0; e < 3; e++) begin : g_dut
    button_input_pio #(
      .WIDTH(WIDTH),
      .EDGE_TYPE(e),
      .DEBOUNCE_CYCLES(DEB)
    ) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .in_port(in_port),
      .readdata(rd_out[e]),
      .irq(irq_out[e])
    );
  end

  // Reference model state: a two-deep delay line for the synchronizer, plus registers.
  logic [WIDTH-1:0] pipe [$];
  logic [WIDTH-1:0] m_stable, m_prev, m_mask;
  logic [WIDTH-1:0] m_cap [3];
  logic             m_irq [3];
  int               m_run [WIDTH];
  logic [WIDTH-1:0] cur_in = '0;

  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void model_reset();
    pipe.delete();
    pipe.push_back('0);
    pipe.push_back('0);
    m_stable = '0;
    m_prev   = '0;
    m_mask   = '0;
    for (int e = 0; e < 3; e++) begin
      m_cap[e] = '0;
      m_irq[e] = 1'b0;
    end
    for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a, input int e);
    case (a)
      2'd0:    return 32'(m_stable);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_cap[e]);
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive at negedge, queue expected outputs, then advance the model by one edge.
  task automatic cycle(input logic rst, input logic [WIDTH-1:0] nin, input logic [1:0] a,
                       input logic c, input logic w, input logic [31:0] d);
    exp_t             x;
    logic [WIDTH-1:0] s2_old, st_n, rise, fall, clr, setv;
    @(negedge clk);
    reset_n    = rst;
    in_port    = nin;
    address    = a;
    chipselect = c;
    write_n    = w;
    writedata  = d;
    cur_in     = nin;
    if (!rst) model_reset();
    x.addr = a;
    for (int e = 0; e < 3; e++) begin
      x.rd[e]  = model_read(a, e);
      x.irq[e] = m_irq[e];
    end
    sb.push_back(x);
    if (rst) begin
      s2_old = pipe.pop_front();
      pipe.push_back(nin);
      st_n = m_stable;
      if (DEB_EN) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (s2_old[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
              st_n[i]  = s2_old[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end else begin
        st_n = pipe[0];
      end
      rise = m_stable & ~m_prev;
      fall = ~m_stable & m_prev;
      clr  = (c && !w && a == 2'd3) ? d[WIDTH-1:0] : '0;
      for (int e = 0; e < 3; e++) begin
        setv     = (e == 0) ? rise : (e == 1) ? fall : (rise | fall);
        m_irq[e] = |(m_cap[e] & m_mask);
        m_cap[e] = (m_cap[e] & ~clr) | setv;
      end
      if (c && !w && a == 2'd2) m_mask = d[WIDTH-1:0];
      m_prev   = m_stable;
      m_stable = st_n;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, cur_in, 2'($urandom_range(3)), 1'b0, 1'b1, $urandom);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle(1'b1, cur_in, a, 1'b1, 1'b0, d);
  endtask

  task automatic rand_cycle(input int unsigned p_tog, input int unsigned p_wr);
    logic [WIDTH-1:0] nin;
    nin = cur_in;
    for (int i = 0; i < WIDTH; i++) if ($urandom_range(99) < p_tog) nin[i] = ~nin[i];
    cycle(1'b1, nin, 2'($urandom_range(3)), 1'($urandom_range(1)),
          !($urandom_range(99) < p_wr), $urandom);
  endtask

  // Monitor: outputs are settled 2 ns after each negedge; pop and compare everything queued.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        x = sb.pop_front();
        for (int e = 0; e < 3; e++) begin
          n_vec++;
          if (rd_out[e] !== x.rd[e]) begin
            n_err++;
            $display("FAIL readdata edge_type=%0d addr=%0d t=%0t got=%h want=%h",
                     e, x.addr, $time, rd_out[e], x.rd[e]);
          end
          n_vec++;
          if (irq_out[e] !== x.irq[e]) begin
            n_err++;
            $display("FAIL irq edge_type=%0d t=%0t got=%b want=%b", e, $time, irq_out[e], x.irq[e]);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    // Reset: every address reads 0.
    for (int a = 0; a < 4; a++) cycle(1'b0, '0, 2'(a), 1'b0, 1'b1, '0);
    for (int a = 0; a < 4; a++) cycle(1'b1, '0, 2'(a), 1'b0, 1'b1, '0);
    // Rising edge on bit 1 with it unmasked, then clear.
    wr(2'd2, 32'h2);
    cycle(1'b1, 4'h2, 2'd3, 1'b0, 1'b1, '0);
    idle(9);
    wr(2'd3, 32'h2);
    idle(3);
    // Masked edge on bit 0, then unmask.
    wr(2'd2, 32'h0);
    cycle(1'b1, 4'h3, 2'd3, 1'b0, 1'b1, '0);
    idle(9);
    wr(2'd2, 32'h1);
    idle(3);
    // Set/clear collision: W1C of bit 3 every cycle while its edge arrives.
    wr(2'd3, 32'hF);
    cycle(1'b1, 4'hB, 2'd3, 1'b1, 1'b0, 32'h8);
    for (int k = 0; k < 9; k++) wr(2'd3, 32'h8);
    cycle(1'b1, 4'h3, 2'd3, 1'b1, 1'b0, 32'h8);
    for (int k = 0; k < 9; k++) wr(2'd3, 32'h8);
    // Short glitch then a long level on bit 1; upper writedata bits must be ignored.
    wr(2'd2, 32'hFFFF_FFF0);
    cycle(1'b1, 4'h1, 2'd0, 1'b0, 1'b1, '0);
    cycle(1'b1, 4'h1, 2'd0, 1'b0, 1'b1, '0);
    cycle(1'b1, 4'h3, 2'd0, 1'b0, 1'b1, '0);
    cycle(1'b1, 4'h3, 2'd0, 1'b0, 1'b1, '0);
    cycle(1'b1, 4'h3, 2'd0, 1'b0, 1'b1, '0);
    cycle(1'b1, 4'h1, 2'd0, 1'b0, 1'b1, '0);
    idle(8);
    cycle(1'b1, 4'h3, 2'd0, 1'b0, 1'b1, '0);
    idle(10);
    // Reset mid-count with inputs held high through release.
    cycle(1'b1, 4'hC, 2'd0, 1'b0, 1'b1, '0);
    idle(3);
    cycle(1'b0, 4'hC, 2'd3, 1'b0, 1'b1, '0);
    cycle(1'b0, 4'hC, 2'd2, 1'b0, 1'b1, '0);
    idle(12);
    // Randomized phases with varying input activity and occasional resets.
    for (int ph = 0; ph < 6; ph++) begin
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(299) == 0) cycle(1'b0, cur_in, 2'($urandom_range(3)), 1'b0, 1'b1, '0);
        else rand_cycle((ph % 3 == 0) ? 40 : (ph % 3 == 1) ? 12 : 3, (ph < 3) ? 30 : 10);
      end
    end
    idle(2);
    @(negedge clk);
    #4;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
